data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the single-port 64-bit data RAM (ram_data) between N_CORES cores.
//   Each core issues one read or write at a time over a req/ack handshake.
//   The arbiter picks one requester, drives the RAM address/data/WR/RD pins,
//   captures read data and returns it with a one-cycle ack.
//   Sits between the core load/store units and ram_data.
// PARAMETERS
//   N_CORES    4    number of requesting cores (2..8)
//   ADDR_W     16   address width, matches ram_data ADDBUS
//   DATA_W     64   data width, matches ram_data DATAIN/DATAOUT
//   MEM_DEPTH  512  number of valid words; addresses >= MEM_DEPTH are out of range
// PORTS
//   clk          in   1               system clock, rising edge
//   rst_n        in   1               reset, asynchronous assert, active-low
//   core_req     in   N_CORES         per-core request; held high until ack
//   core_wr      in   N_CORES         per-core 1=write, 0=read; valid with req
//   core_addr    in   N_CORES*ADDR_W  per-core word address, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata   in   N_CORES*DATA_W  per-core write data, same packing
//   core_ack     out  N_CORES         one-hot ack pulse, one cycle
//   core_rdata   out  DATA_W          read data, valid while ack is high (read only)
//   mem_addr     out  ADDR_W          to ram_data ADDBUS
//   mem_wdata    out  DATA_W          to ram_data DATAIN
//   mem_wr       out  1               to ram_data WR
//   mem_rd       out  1               to ram_data RD
//   mem_rdata    in   DATA_W          from ram_data DATAOUT (high-Z when RD low)
//   busy         out  1               high in ACCESS and RESP
// BEHAVIOUR
//   - One clock domain. Reset is asynchronous and active-low.
//   - Reset values: all outputs 0, state IDLE, rr_ptr 0. An in-flight transaction is dropped.
//     No ack is issued for it. A write is not committed unless mem_wr was sampled by a clk edge before reset.
//   - FSM: IDLE -> ACCESS -> RESP -> IDLE. Exactly one transaction per 3 cycles.
//   - IDLE: if |core_req, select winner idx (arbitration below).
//     Latch idx, addr, wdata and wr; go to ACCESS. Otherwise stay in IDLE.
//   - ACCESS:
//     - mem_addr = latched addr. For a write, mem_wdata = wdata and mem_wr=1;
//       ram_data commits at the closing edge.
//     - For a read, mem_rd=1. mem_rdata is registered into core_rdata at the closing edge.
//   - RESP: core_ack[idx]=1 for this cycle only. core_rdata is held. Set rr_ptr = (idx+1) mod N_CORES.
//   - Latency: req sampled in IDLE at cycle n -> ack high in cycle n+2.
//   - mem_wr and mem_rd are never high together. Both are 0 outside ACCESS.
//     mem_addr and mem_wdata are 0 outside ACCESS.
//   - Handshake: the core must hold req/wr/addr/wdata stable until ack.
//     It must drop req the cycle after ack; a req still high in the next IDLE is a new request.
//     Arbiter inputs are sampled only in IDLE; changes in ACCESS/RESP are ignored.
//   - Arbitration (default): round-robin. Winner is the first requester scanning idx = rr_ptr,
//     rr_ptr+1, ... with wrap at N_CORES-1 -> 0.
//   - Out-of-range (addr >= MEM_DEPTH):
//     - write: mem_wr stays 0 and memory is unchanged.
//     - read: mem_rd stays 0 and core_rdata = 0.
//     - The ack is still issued at normal latency.
//   - core_rdata after a write ack is unchanged (keeps previous value).
// CONFIGURATION
//   ARB_FIXED_PRIO_EN defined: fixed priority, lowest index requester always wins.
//     rr_ptr is not updated; core 0 can starve the others.
//   ARB_FIXED_PRIO_EN undefined: round-robin as above (default build).
// TESTING
//   1. After reset, core1 reads addr 3 -> mem_rd=1 in cycle n+1; core_ack=4'b0010 in n+2;
//      core_rdata=64'h0005_0006_0007_0008.
//   2. core0 writes 64'hDEAD_BEEF_0123_4567 to addr 10, then reads addr 10
//      -> second ack returns 64'hDEAD_BEEF_0123_4567; each transaction takes 3 cycles.
//   3. All 4 cores request reads (addr 0..3) in the same cycle after reset
//      -> acks in order core0,1,2,3, 3 cycles apart.
//      With ARB_FIXED_PRIO_EN and core0 re-requesting -> core0 is acked every time.
//   4. core2 writes addr 600 then reads addr 600 -> both acked; mem_wr never 1; read core_rdata=0.
//   5. Assert rst_n=0 during ACCESS of a core3 write
//      -> all outputs 0 immediately; no ack; memory unchanged.
//      After release, core3's held req is served from IDLE normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between N_CORES cores.
// Each transaction runs IDLE -> ACCESS -> RESP, so one transaction takes 3 cycles.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority, where the lowest
// index wins. The default build uses round-robin arbitration.
module data_mem_arbiter #(
   parameter int N_CORES   = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 64,
   parameter int MEM_DEPTH = 512
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_CORES-1:0]          core_req_i,
   input  logic [N_CORES-1:0]          core_wr_i,
   input  logic [N_CORES*ADDR_W-1:0]   core_addr_i,
   input  logic [N_CORES*DATA_W-1:0]   core_wdata_i,
   output logic [N_CORES-1:0]          core_ack_o,
   output logic [DATA_W-1:0]           core_rdata_o,
   output logic [ADDR_W-1:0]           mem_addr_o,
   output logic [DATA_W-1:0]           mem_wdata_o,
   output logic                        mem_wr_o,
   output logic                        mem_rd_o,
   input  logic [DATA_W-1:0]           mem_rdata_i,
   output logic                        busy_o
);

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   // One extra bit so that a MEM_DEPTH equal to 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

   logic [1:0]        state_q,  state_d;
   logic [IDX_W-1:0]  idx_q,    idx_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [DATA_W-1:0] wdata_q,  wdata_d;
   logic              wr_q,     wr_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;

   logic              win_valid;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  cand;
   logic              in_range;

   assign in_range = ({1'b0, addr_q} < DEPTH_C);

   // Pick the winning requester from the live request vector.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      // Scan from the last candidate down to the first so that the
      // earliest candidate in the scan order is the one that survives.
      for (int k = N_CORES - 1; k >= 0; k--) begin
`ifdef ARB_FIXED_PRIO_EN
         cand = IDX_W'(k);
`else
         cand = IDX_W'((int'(rr_ptr_q) + k) % N_CORES);
`endif
         if (core_req_i[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state logic for the FSM and the latched transaction fields.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      rr_ptr_d = rr_ptr_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = ACCESS;
               idx_d   = win_idx;
               addr_d  = core_addr_i[win_idx*ADDR_W +: ADDR_W];
               wdata_d = core_wdata_i[win_idx*DATA_W +: DATA_W];
               wr_d    = core_wr_i[win_idx];
            end
         end
         ACCESS: begin
            state_d = RESP;
            // An out-of-range read returns zero. A write leaves the read data untouched.
            if (!wr_q) begin
               rdata_d = in_range ? mem_rdata_i : '0;
            end
         end
         RESP: begin
            state_d = IDLE;
            // In fixed-priority mode the pointer stays at zero.
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_d = (idx_q == IDX_W'(N_CORES - 1)) ? '0 : idx_q + 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers. Reset drops any transaction that is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rr_ptr_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         rr_ptr_q <= rr_ptr_d;
         rdata_q  <= rdata_d;
      end
   end

   // Drive the RAM pins only during ACCESS. Out-of-range accesses never strobe the RAM.
   assign mem_addr_o   = (state_q == ACCESS) ? addr_q : '0;
   assign mem_wdata_o  = (state_q == ACCESS && wr_q) ? wdata_q : '0;
   assign mem_wr_o     = (state_q == ACCESS) &&  wr_q && in_range;
   assign mem_rd_o     = (state_q == ACCESS) && !wr_q && in_range;
   assign busy_o       = (state_q != IDLE);
   assign core_rdata_o = rdata_q;

   // Drive a one-hot acknowledge to the winning core during RESP.
   generate
      for (genvar gi = 0; gi < N_CORES; gi++) begin : g_ack
         assign core_ack_o[gi] = (state_q == RESP) && (idx_q == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter in its default round-robin build.
// A behavioural RAM model sits on the memory pins.
module tb_data_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   core_req;
   logic [3:0]   core_wr;
   logic [63:0]  core_addr;
   logic [255:0] core_wdata;
   logic [3:0]   core_ack;
   logic [63:0]  core_rdata;
   logic [15:0]  mem_addr;
   logic [63:0]  mem_wdata;
   logic         mem_wr;
   logic         mem_rd;
   logic [63:0]  mem_rdata;
   logic         busy;

   logic [63:0]  ram [0:511];
   int           tests = 0;
   int           fails = 0;
   int           wr_count = 0;
   int           rd_count = 0;
   int           both_count = 0;
   int           cyc;
   int           wr_before;
   int           rd_before;
   logic [3:0]   one = 4'b0001;

   data_mem_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req_i  (core_req),
      .core_wr_i   (core_wr),
      .core_addr_i (core_addr),
      .core_wdata_i(core_wdata),
      .core_ack_o  (core_ack),
      .core_rdata_o(core_rdata),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_wr_o    (mem_wr),
      .mem_rd_o    (mem_rd),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   // Read path of the RAM model. A floating bus is modelled as a garbage
   // pattern, so a stray capture of it shows up in the checks.
   assign mem_rdata = mem_rd ? ram[mem_addr[8:0]] : 64'hBADB_ADBA_DBAD_BAD0;

   // Write path of the RAM model, plus counters that track pin activity.
   always @(posedge clk) begin
      if (mem_wr) ram[mem_addr[8:0]] <= mem_wdata;
      if (mem_wr) wr_count <= wr_count + 1;
      if (mem_rd) rd_count <= rd_count + 1;
      if (mem_wr && mem_rd) both_count <= both_count + 1;
   end

   function automatic logic [63:0] pat(input int a);
      return {16'(a + 2), 16'(a + 3), 16'(a + 4), 16'(a + 5)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input int k, input logic wr, input logic [15:0] a, input logic [63:0] d);
      core_req[k]            = 1'b1;
      core_wr[k]             = wr;
      core_addr[k*16 +: 16]  = a;
      core_wdata[k*64 +: 64] = d;
   endtask

   // Wait, with a bound, for the next ack. Report how many edges it took.
   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (core_ack == 4'b0000 && n < 10);
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = pat(i);
      rst_n = 1'b0; core_req = '0; core_wr = '0; core_addr = '0; core_wdata = '0;
      step; step;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ack", 64'(core_ack), 64'd0);
      check("rst_rdata", core_rdata, 64'd0);
      check("rst_pins", {46'd0, mem_wr, mem_rd, mem_addr}, 64'd0);
      rst_n = 1'b1;
      step;

      // Test 1: core1 reads addr 3.
      set_core(1, 1'b0, 16'd3, 64'd0);
      step;
      check("t1_mem_rd", 64'(mem_rd), 64'd1);
      check("t1_mem_wr", 64'(mem_wr), 64'd0);
      check("t1_mem_addr", 64'(mem_addr), 64'd3);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_no_early_ack", 64'(core_ack), 64'd0);
      step;
      check("t1_ack", 64'(core_ack), 64'b0010);
      check("t1_rdata", core_rdata, 64'h0005_0006_0007_0008);
      core_req[1] = 1'b0;
      step;
      check("t1_ack_one_cycle", 64'(core_ack), 64'd0);
      check("t1_idle_busy", 64'(busy), 64'd0);
      check("t1_rdata_held", core_rdata, 64'h0005_0006_0007_0008);

      // Test 2: core0 writes addr 10, then reads it back.
      set_core(0, 1'b1, 16'd10, 64'hDEAD_BEEF_0123_4567);
      step;
      check("t2_mem_wr", 64'(mem_wr), 64'd1);
      check("t2_mem_rd", 64'(mem_rd), 64'd0);
      check("t2_mem_addr", 64'(mem_addr), 64'd10);
      check("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0123_4567);
      step;
      check("t2_wr_ack", 64'(core_ack), 64'b0001);
      check("t2_wr_keeps_rdata", core_rdata, 64'h0005_0006_0007_0008);
      check("t2_ram", ram[10], 64'hDEAD_BEEF_0123_4567);
      core_req[0] = 1'b0;
      step;
      check("t2_pins_idle", {mem_wdata[47:0], mem_addr}, 64'd0);
      set_core(0, 1'b0, 16'd10, 64'd0);
      wait_ack(cyc);
      check("t2_rd_latency", 64'(cyc), 64'd2);
      check("t2_rd_ack", 64'(core_ack), 64'b0001);
      check("t2_rd_rdata", core_rdata, 64'hDEAD_BEEF_0123_4567);
      core_req[0] = 1'b0;
      step;

      // Test 4: core2 writes and reads the out-of-range address 600.
      wr_before = wr_count;
      rd_before = rd_count;
      set_core(2, 1'b1, 16'd600, 64'h1234_5678_9ABC_DEF0);
      wait_ack(cyc);
      check("t4_wr_latency", 64'(cyc), 64'd2);
      check("t4_wr_ack", 64'(core_ack), 64'b0100);
      core_req[2] = 1'b0;
      step;
      set_core(2, 1'b0, 16'd600, 64'd0);
      wait_ack(cyc);
      check("t4_rd_ack", 64'(core_ack), 64'b0100);
      check("t4_rd_rdata", core_rdata, 64'd0);
      check("t4_no_mem_wr", 64'(wr_count - wr_before), 64'd0);
      check("t4_no_mem_rd", 64'(rd_count - rd_before), 64'd0);
      core_req[2] = 1'b0;
      step;

      // Round-robin order: the pointer is now 3, so core3 wins ahead of core1.
      set_core(1, 1'b0, 16'd1, 64'd0);
      set_core(3, 1'b0, 16'd5, 64'd0);
      wait_ack(cyc);
      check("rr_first_ack", 64'(core_ack), 64'b1000);
      check("rr_first_rdata", core_rdata, pat(5));
      core_req[3] = 1'b0;
      wait_ack(cyc);
      check("rr_second_gap", 64'(cyc), 64'd3);
      check("rr_second_ack", 64'(core_ack), 64'b0010);
      check("rr_second_rdata", core_rdata, pat(1));
      core_req[1] = 1'b0;
      step;

      // Test 3: reset, then all four cores request reads at once.
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_core(k, 1'b0, 16'(k), 64'd0);
      for (int k = 0; k < 4; k++) begin
         wait_ack(cyc);
         check($sformatf("t3_gap_core%0d", k), 64'(cyc), (k == 0) ? 64'd2 : 64'd3);
         check($sformatf("t3_ack_core%0d", k), 64'(core_ack), 64'(one << k));
         check($sformatf("t3_rdata_core%0d", k), core_rdata, pat(k));
         core_req[k] = 1'b0;
      end
      step;

      // Test 5: reset lands during the ACCESS cycle of a core3 write.
      set_core(3, 1'b1, 16'd20, 64'h1111_2222_3333_4444);
      step;
      check("t5_mem_wr_before", 64'(mem_wr), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_pins", {46'd0, mem_wr, mem_rd, mem_addr}, 64'd0);
      check("t5_rst_wdata", mem_wdata, 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_rdata", core_rdata, 64'd0);
      step;
      check("t5_no_ack", 64'(core_ack), 64'd0);
      check("t5_ram_unchanged", ram[20], pat(20));
      #2 rst_n = 1'b1;
      wait_ack(cyc);
      check("t5_retry_latency", 64'(cyc), 64'd2);
      check("t5_retry_ack", 64'(core_ack), 64'b1000);
      check("t5_ram_written", ram[20], 64'h1111_2222_3333_4444);
      core_req[3] = 1'b0;
      step;

      check("never_wr_and_rd", 64'(both_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
